// File: rtl/bit4_adder.sv
// 4-bit unsigned ripple-carry adder built from four full-adder cells.
// The sum and carry-out are registered; reset clears them asynchronously.

module bit4_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

module bit4_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] SUM,
    output logic       C_out
);

    logic [4:0] carry;
    logic [3:0] raw_sum;
    logic [3:0] sum_d;
    logic [3:0] sum_q;
    logic       c_out_d;
    logic       c_out_q;

    assign carry[0] = 1'b0;

    // carry[i+1] from cell i feeds cell i+1; carry[4] is the raw carry-out
    for (genvar i = 0; i < 4; i++) begin : g_fa
        bit4_fa_cell u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry[i]),
            .s    (raw_sum[i]),
            .cout (carry[i+1])
        );
    end

    always_comb begin
        sum_d   = raw_sum;
        c_out_d = carry[4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= 4'b0000;
            c_out_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

    assign SUM   = sum_q;
    assign C_out = c_out_q;

endmodule

// File: tb/tb_bit4_adder.sv
// Directed and exhaustive bench for bit4_adder.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.

module tb_bit4_adder;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] SUM;
    logic       C_out;

    int n_vec;
    int n_err;

    bit4_adder dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .SUM   (SUM),
        .C_out (C_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] got,
                       input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    task automatic apply(input string tag, input logic [3:0] a,
                         input logic [3:0] b, input logic [4:0] exp);
        @(negedge clk);
        A = a;
        B = b;
        @(posedge clk);
        #1;
        chk(tag, {C_out, SUM}, exp);
    endtask

    initial begin
        logic [4:0] exp;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        A     = 4'b1111;
        B     = 4'b1111;

        #2 rst = 1'b1;
        #1 chk("rst_immediate", {C_out, SUM}, 5'b00000);
        repeat (2) @(posedge clk);
        #1 chk("rst_held", {C_out, SUM}, 5'b00000);

        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_release_hold", {C_out, SUM}, 5'b00000);
        @(posedge clk);
        #1 chk("rst_release_edge", {C_out, SUM}, 5'b11110);

        apply("carry_all", 4'b1001, 4'b0111, 5'b10000);
        apply("wrap_low", 4'b0011, 4'b1110, 5'b10001);
        apply("no_carry", 4'b0111, 4'b1000, 5'b01111);
        apply("full_ripple", 4'b1111, 4'b0001, 5'b10000);

        // Mid-cycle operand change must not reach the outputs before the edge
        A = 4'b0101;
        B = 4'b0110;
        #3 chk("hold_mid", {C_out, SUM}, 5'b10000);
        @(posedge clk);
        #1 chk("hold_next_edge", {C_out, SUM}, 5'b01011);

        // Back-to-back pairs on consecutive edges
        A = 4'b0001;
        B = 4'b0010;
        @(posedge clk);
        #1 chk("b2b_0", {C_out, SUM}, 5'b00011);
        A = 4'b1000;
        B = 4'b1000;
        @(posedge clk);
        #1 chk("b2b_1", {C_out, SUM}, 5'b10000);
        A = 4'b1100;
        B = 4'b0101;
        @(posedge clk);
        #1 chk("b2b_2", {C_out, SUM}, 5'b10001);

        for (int i = 0; i < 256; i++) begin
            exp = {1'b0, i[7:4]} + {1'b0, i[3:0]};
            apply("exhaustive", i[7:4], i[3:0], exp);
        end

        // Asynchronous reset assertion mid-cycle after a nonzero result
        #2 rst = 1'b1;
        #1 chk("rst_async_mid", {C_out, SUM}, 5'b00000);
        @(posedge clk);
        #1 chk("rst_async_held", {C_out, SUM}, 5'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
